// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction-fetch controller: owns the PC, handshakes with instruction memory and decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_sequencer #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    input  logic            if_ready,
    output logic            busy
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            fetch_fault
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        S_FAULT
`endif
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] if_pc_n;
    logic [31:0]     if_instr_n;
    logic            drop, drop_n;
    logic [XLEN-1:0] target;
    state_t          next_fetch;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault, fault_n;
    logic misaligned;
    logic in_flight;

    assign target     = redirect_target;
    assign misaligned = (redirect_target[1:0] != 2'b00);
    // A response still owed by memory must be swallowed after the trap is left.
    assign in_flight  = (state == S_REQ && imem_gnt) || (state == S_WAIT && !imem_rvalid)
                      || (state == S_FAULT && drop && !imem_rvalid);
    assign fetch_fault = fault;
`else
    logic [1:0] unused_target_bits;

    assign target             = {redirect_target[XLEN-1:2], 2'b00};
    assign unused_target_bits = redirect_target[1:0];
`endif

    assign next_fetch = run ? S_REQ : S_IDLE;
    assign imem_req   = (state == S_REQ);
    assign imem_addr  = pc;
    assign if_valid   = (state == S_OUT);
    assign busy       = (state != S_IDLE);

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        drop_n     = drop;
        if_pc_n    = if_pc;
        if_instr_n = if_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_n    = fault;
`endif
        case (state)
            S_IDLE: if (run) state_n = S_REQ;
            S_REQ:  if (imem_gnt) state_n = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop) begin
                        drop_n  = 1'b0;
                        state_n = next_fetch;
                    end else begin
                        if_instr_n = imem_rdata;
                        if_pc_n    = pc;
                        state_n    = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (if_ready) begin
                    pc_n    = pc + XLEN'(4);
                    state_n = next_fetch;
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            S_FAULT: if (drop && imem_rvalid) drop_n = 1'b0;
`endif
            default: state_n = S_IDLE;
        endcase

        // Redirect overrides whatever the handshake logic above decided.
        if (redirect_valid) begin
            pc_n = target;
            case (state)
                S_REQ:  if (imem_gnt) drop_n = 1'b1;
                S_WAIT: begin
                    if_pc_n    = if_pc;
                    if_instr_n = if_instr;
                    if (imem_rvalid) begin
                        drop_n  = 1'b0;
                        state_n = next_fetch;
                    end else begin
                        drop_n  = 1'b1;
                        state_n = S_WAIT;
                    end
                end
                S_OUT:   state_n = next_fetch;
                default: ;
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            if (misaligned) begin
                fault_n = 1'b1;
                drop_n  = in_flight;
                state_n = S_FAULT;
            end else if (state == S_FAULT) begin
                fault_n = 1'b0;
                state_n = drop_n ? S_WAIT : next_fetch;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            drop     <= drop_n;
            if_pc    <= if_pc_n;
            if_instr <= if_instr_n;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault    <= fault_n;
`endif
        end
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle instruction-fetch controller for the sequential core.
- Owns the architectural PC and sequences each fetch: request to instruction memory, wait for data, hand the instruction to decode.
- Applies branch/jump redirects and keeps the PC at +4 otherwise.
- Sits between the instruction-memory port and the decode stage. Replaces the free-running PC increment with handshake-gated updates.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  fetch enable; low = stop fetching after the current fetch completes.
- redirect_valid  input  1  single-cycle branch/jump redirect strobe.
- redirect_target  input  XLEN  new PC when redirect_valid=1.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  XLEN  fetch address; equals pc.
- imem_gnt  input  1  memory accepted the request this cycle (sampled only when imem_req=1).
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  instruction available to decode.
- if_pc  output  XLEN  PC of the presented instruction.
- if_instr  output  32  presented instruction.
- if_ready  input  1  decode accepts the instruction.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async) values: state=IDLE, pc=RESET_PC, imem_req=0, if_valid=0, if_pc=0, if_instr=0, drop=0, busy=0.
- A late imem_rvalid after reset is ignored.
- States and transitions:
  - IDLE: imem_req=0. run=1 → REQ.
  - REQ: imem_req=1, imem_addr=pc. imem_gnt=1 → WAIT. Otherwise stay; imem_addr stays stable unless a redirect occurs.
  - WAIT: imem_req=0. imem_rvalid is sampled only in this state. On imem_rvalid:
    - drop=0: latch if_instr=imem_rdata, if_pc=pc; go to OUT.
    - drop=1: discard data, clear drop; go to REQ if run, else IDLE.
  - OUT: if_valid=1; if_pc and if_instr held stable. On if_valid&&if_ready: pc<=pc+4; go to REQ if run, else IDLE.
- pc+4 arithmetic is modulo 2^XLEN (wraps all-ones-minus-3 → 0).
- Minimum latency: run high at cycle 0 → imem_req at cycle 1. With gnt at cycle 1 and rvalid at cycle 2, if_valid rises at cycle 3. Peak throughput is 1 instruction per 3 cycles.
- Redirect (highest priority, legal in any state): pc<=redirect_target next cycle.
  - IDLE: pc updated only; stays IDLE unless run=1.
  - REQ without gnt in the same cycle: stay in REQ; imem_addr takes the new pc next cycle. This is the only permitted address change while imem_req=1.
  - REQ with gnt in the same cycle: go to WAIT with drop=1.
  - WAIT: drop<=1; the pending response is discarded, then a refetch is issued from the new pc.
  - OUT: if_valid drops next cycle; go to REQ (or IDLE if run=0). If if_ready=1 in the same cycle, the instruction counts as consumed, but pc takes redirect_target, not pc+4.
- run deasserted mid-fetch: the in-flight fetch completes and is delivered. Next state after OUT handshake or drop completion is IDLE.
- busy = (state != IDLE).

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_fault (1 bit, reset 0) and state FAULT.
  - A redirect with target[1:0]!=0 sets pc=target, fetch_fault=1, state FAULT, and cancels any OUT instruction.
  - In FAULT: imem_req=0, if_valid=0.
  - Leaves FAULT only on a redirect with an aligned target (fetch_fault<=0, then normal redirect behaviour) or on reset.
- Undefined: redirect_target[1:0] is forced to 2'b00 when loaded into pc; there is no fault port or FAULT state.

Test Plan:
- Reset then run=1, gnt immediate, rvalid 1 cycle after gnt, if_ready=1 → if_pc sequence 0x0,0x4,0x8; if_valid every 3rd cycle; imem_addr matches.
- Decode backpressure: if_ready=0 for 5 cycles in OUT → if_valid, if_pc, if_instr stable; pc not incremented; no imem_req.
- Redirect to 0x1000 during WAIT; stale rvalid returns 0xDEADBEEF → not presented; next imem_addr=0x1000; if_pc=0x1000.
- Redirect to 0x200 in the same cycle as an OUT handshake at pc=0x40 → next request addr 0x200, not 0x44.
- pc=64'hFFFF_FFFF_FFFF_FFFC, handshake → next imem_addr=0x0. Separately, run=0 during WAIT → instruction delivered, then IDLE, busy=0.
- Assert rst during WAIT, then rvalid pulse → if_valid stays 0, pc=RESET_PC. With FETCH_MISALIGN_CHECK_EN: redirect to 0x102 → fetch_fault=1, no imem_req; then redirect to 0x100 → fault clears and fetch proceeds from 0x100.
